elevator_call_panel: RTL and testbench

- Request-side counterpart of the elevator controller. Turns raw floor-call buttons into the `req` vector the lift FSM consumes.
- Synchronises and debounces each button, latches one pending call per floor, and clears a call when the lift reports service (stopped at that floor, door open).
- Reports a one-cycle serve event, a pending-call count, and a sticky fault when calls stay unserved too long.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/call_debouncer.sv | 52 +++++
 rtl/elevator_call_panel.sv | 141 ++++++++++++++
 tb/tb_elevator_call_panel.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared defaults and watchdog state encoding for the elevator call panel.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF    = 3;
    localparam int FLOOR_W_DEF       = 2;
    localparam int CNT_W_DEF         = 2;
    localparam int DB_CYCLES_DEF     = 4;
    localparam int STUCK_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        WD_IDLE  = 2'd0,
        WD_COUNT = 2'd1,
        WD_FAULT = 2'd2
    } wd_state_t;

endpackage

// File: rtl/call_debouncer.sv
// One call button: two-flop synchroniser, stability counter and a press pulse
// that fires combinationally on the edge where the debounced level rises.
module call_debouncer #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip;

    // The counter only ever reaches DB_CYCLES-1; the next differing sample flips db.
    always_comb begin
        flip  = (s2_q != db_q) && (cnt_q == CW'(DB_CYCLES - 1));
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (flip) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = flip && s2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= btn;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/elevator_call_panel.sv
// Floor-call panel: debounces buttons, latches one call per floor, clears it
// on service, and raises a sticky fault if calls wait too long unserved.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int FLOOR_W       = FLOOR_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int STUCK_TIMEOUT = STUCK_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  moving,
    output logic [NUM_FLOORS-1:0] req,
    output logic [CNT_W-1:0]      pending_cnt,
    output logic                  served,
    output logic [FLOOR_W-1:0]    served_floor,
    output logic                  fault
);

    localparam int               WD_W     = $clog2(STUCK_TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(STUCK_TIMEOUT);

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] at_floor;
    logic [NUM_FLOORS-1:0] serve_hit;
    logic [NUM_FLOORS-1:0] req_q;
    logic [NUM_FLOORS-1:0] req_d;
    logic                  served_q;
    logic                  served_d;
    logic [FLOOR_W-1:0]    served_floor_q;
    logic [FLOOR_W-1:0]    served_floor_d;
    logic [CNT_W-1:0]      pending_cnt_d;
    logic                  serve_any;

    wd_state_t             wd_state_q;
    logic [WD_W-1:0]       wd_cnt_q;
    logic                  fault_q;

    // Serve beats a simultaneous press; a press while stopped here with the door open is absorbed.
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            call_debouncer #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .clk  (clk),
                .reset(reset),
                .btn  (btn[gi]),
                .press(press[gi])
            );

            assign at_floor[gi]  = door_open && !moving && (current_floor == FLOOR_W'(gi));
            assign serve_hit[gi] = at_floor[gi] && req_q[gi];
            assign req_d[gi]     = !serve_hit[gi] && (req_q[gi] || (press[gi] && !at_floor[gi]));
        end
    endgenerate

    assign serve_any = |serve_hit;
    assign served_d  = serve_any;

    always_comb begin
        served_floor_d = served_floor_q;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (serve_hit[f]) begin
                served_floor_d = FLOOR_W'(f);
            end
        end
    end

    always_comb begin
        pending_cnt_d = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            pending_cnt_d = pending_cnt_d + CNT_W'(req_q[f]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q          <= '0;
            served_q       <= 1'b0;
            served_floor_q <= '0;
        end else begin
            req_q          <= req_d;
            served_q       <= served_d;
            served_floor_q <= served_floor_d;
        end
    end

    // Watchdog: counter saturates at the limit, fault holds until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_state_q <= WD_IDLE;
            wd_cnt_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (wd_state_q)
                WD_IDLE: begin
                    if (req_q != '0) begin
                        wd_cnt_q <= WD_W'(1);
                        if (WD_LIMIT <= WD_W'(1)) begin
                            wd_state_q <= WD_FAULT;
                            fault_q    <= 1'b1;
                        end else begin
                            wd_state_q <= WD_COUNT;
                        end
                    end
                end
                WD_COUNT: begin
                    if (serve_any || (req_q == '0)) begin
                        wd_state_q <= WD_IDLE;
                        wd_cnt_q   <= '0;
                    end else if ((wd_cnt_q + WD_W'(1)) >= WD_LIMIT) begin
                        wd_state_q <= WD_FAULT;
                        wd_cnt_q   <= WD_LIMIT;
                        fault_q    <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end
                WD_FAULT: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    wd_state_q <= WD_IDLE;
                    wd_cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req          = req_q;
    assign pending_cnt  = pending_cnt_d;
    assign served       = served_q;
    assign served_floor = served_floor_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed scoreboard bench for elevator_call_panel: stimulus queues expected
// state per edge and expected serve events; monitors compare on the negedge.
module tb_elevator_call_panel;

    logic       clk;
    logic       reset;
    logic [2:0] btn;
    logic [1:0] current_floor;
    logic       door_open;
    logic       moving;
    logic [2:0] req;
    logic [1:0] pending_cnt;
    logic       served;
    logic [1:0] served_floor;
    logic       fault;

    elevator_call_panel dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .current_floor(current_floor),
        .door_open    (door_open),
        .moving       (moving),
        .req          (req),
        .pending_cnt  (pending_cnt),
        .served       (served),
        .served_floor (served_floor),
        .fault        (fault)
    );

    typedef struct {
        int         at;
        string      name;
        logic [2:0] req;
        logic [1:0] cnt;
        logic       served;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];
    int   srv_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edges = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    function automatic void expect_at(int at, string nm, logic [2:0] r, logic [1:0] c,
                                      logic s, logic f);
        exp_t e;
        e.at = at; e.name = nm; e.req = r; e.cnt = c; e.served = s; e.fault = f;
        exp_q.push_back(e);
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; btn = '0; current_floor = '0; door_open = 1'b0; moving = 1'b0;
        expect_at(edges + 2, "reset_state", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(2);
        reset = 1'b1;
    endtask

    // State monitor: compares every queued expectation due at this edge.
    always @(negedge clk) begin
        exp_t e;
        int   fl;
        while (exp_q.size() > 0 && exp_q[0].at <= edges) begin
            e = exp_q.pop_front();
            tests++;
            if (e.at < edges) begin
                fails++;
                $display("FAIL %s: check for edge %0d missed (now edge %0d)", e.name, e.at, edges);
            end else if (req !== e.req || pending_cnt !== e.cnt || served !== e.served ||
                         fault !== e.fault) begin
                fails++;
                $display("FAIL %s @edge %0d: got req=%b cnt=%0d served=%b fault=%b, want req=%b cnt=%0d served=%b fault=%b",
                         e.name, edges, req, pending_cnt, served, fault,
                         e.req, e.cnt, e.served, e.fault);
            end else begin
                $display("[TB] ok %s @edge %0d req=%b cnt=%0d served=%b fault=%b",
                         e.name, edges, req, pending_cnt, served, fault);
            end
        end
        // Serve-event monitor: every served pulse must match a queued floor.
        if (served === 1'b1) begin
            tests++;
            if (srv_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_serve @edge %0d: got served_floor=%0d, want no serve",
                         edges, served_floor);
            end else begin
                fl = srv_q.pop_front();
                if (served_floor !== 2'(fl)) begin
                    fails++;
                    $display("FAIL serve_floor @edge %0d: got %0d, want %0d", edges, served_floor, fl);
                end else begin
                    $display("[TB] ok serve_event @edge %0d floor=%0d", edges, served_floor);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0; btn = '0; current_floor = '0; door_open = 1'b0; moving = 1'b0;

        // Press latch, latency and release
        do_reset();
        n = edges; btn = 3'b010;
        expect_at(n + 5, "latency_edge4", 3'b000, 2'd0, 1'b0, 1'b0);
        expect_at(n + 6, "press_latch",   3'b010, 2'd1, 1'b0, 1'b0);
        tick(6);
        btn = '0; n = edges;
        expect_at(n + 10, "release_no_event", 3'b010, 2'd1, 1'b0, 1'b0);
        tick(10);

        // Glitch shorter than the debounce window, then exactly the window
        do_reset();
        btn = 3'b100; tick(3); btn = '0; n = edges;
        expect_at(n + 3,  "glitch_a", 3'b000, 2'd0, 1'b0, 1'b0);
        expect_at(n + 10, "glitch_b", 3'b000, 2'd0, 1'b0, 1'b0);
        expect_at(n + 20, "glitch_c", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(20);
        n = edges; btn = 3'b100; tick(4); btn = '0;
        expect_at(n + 5, "pulse4_edge",  3'b000, 2'd0, 1'b0, 1'b0);
        expect_at(n + 6, "pulse4_latch", 3'b100, 2'd1, 1'b0, 1'b0);
        tick(10);

        // Serve, invalid floor, moving lift
        do_reset();
        n = edges; btn = 3'b110;
        expect_at(n + 6, "two_calls", 3'b110, 2'd2, 1'b0, 1'b0);
        tick(6);
        btn = '0; current_floor = 2'd3; door_open = 1'b1; n = edges;
        expect_at(n + 1, "floor3_no_serve", 3'b110, 2'd2, 1'b0, 1'b0);
        tick(1);
        current_floor = 2'd1; n = edges; srv_q.push_back(1);
        expect_at(n + 1, "serve_f1",        3'b100, 2'd1, 1'b1, 1'b0);
        expect_at(n + 2, "serve_pulse_end", 3'b100, 2'd1, 1'b0, 1'b0);
        tick(2);
        current_floor = 2'd2; moving = 1'b1; n = edges;
        expect_at(n + 1, "moving_no_serve", 3'b100, 2'd1, 1'b0, 1'b0);
        tick(1);
        moving = 1'b0; n = edges; srv_q.push_back(2);
        expect_at(n + 1, "serve_f2",     3'b000, 2'd0, 1'b1, 1'b0);
        expect_at(n + 2, "serve_f2_end", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(2);
        door_open = 1'b0;

        // Absorbed press at the open-door floor, other floor latches
        do_reset();
        current_floor = 2'd2; door_open = 1'b1; btn = 3'b101; n = edges;
        expect_at(n + 6,  "absorb_latch0", 3'b001, 2'd1, 1'b0, 1'b0);
        expect_at(n + 12, "absorb_hold",   3'b001, 2'd1, 1'b0, 1'b0);
        tick(12);
        btn = '0; door_open = 1'b0;
        tick(2);

        // Watchdog timeout and sticky fault
        do_reset();
        current_floor = 2'd2; btn = 3'b001; n = edges;
        expect_at(n + 6,  "wd_req",    3'b001, 2'd1, 1'b0, 1'b0);
        expect_at(n + 69, "wd_before", 3'b001, 2'd1, 1'b0, 1'b0);
        expect_at(n + 70, "wd_fault",  3'b001, 2'd1, 1'b0, 1'b1);
        tick(8);
        btn = '0;
        tick(64);
        current_floor = 2'd0; door_open = 1'b1; n = edges; srv_q.push_back(0);
        expect_at(n + 1, "wd_serve_sticky", 3'b000, 2'd0, 1'b1, 1'b1);
        expect_at(n + 4, "wd_still_fault",  3'b000, 2'd0, 1'b0, 1'b1);
        tick(4);
        door_open = 1'b0;

        // Reset mid-operation with a button held through it
        current_floor = 2'd3; btn = 3'b111; n = edges;
        expect_at(n + 6, "all_calls", 3'b111, 2'd3, 1'b0, 1'b1);
        tick(6);
        reset = 1'b0; btn = 3'b001; current_floor = 2'd0; n = edges;
        expect_at(n + 1, "rst_mid", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b1; n = edges;
        expect_at(n + 5, "relatch_edge4", 3'b000, 2'd0, 1'b0, 1'b0);
        expect_at(n + 6, "relatch",       3'b001, 2'd1, 1'b0, 1'b0);
        tick(8);
        btn = '0;
        tick(2);
        #1;

        tests++;
        if (exp_q.size() != 0 || srv_q.size() != 0) begin
            fails++;
            $display("FAIL leftovers: got %0d state checks and %0d serve events pending, want 0 and 0",
                     exp_q.size(), srv_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
